// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants: default width, opcodes, flag indices
package alu_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_XOR  = 4'd2,
        OP_NAND = 4'd3
    } alu_op_e;

    localparam int FLAG_ZERO   = 0;
    localparam int FLAG_ONES   = 1;
    localparam int FLAG_PARITY = 2;
    localparam int FLAG_W      = 3;

endpackage

// File: rtl/nand_bit.sv
// rtl/nand_bit.sv - single-lane NAND cell
module nand_bit (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a & b);

endmodule

// File: rtl/nand_gate.sv
// rtl/nand_gate.sv - bitwise NAND ALU unit with flags and a registered output stage
module nand_gate
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ones,
    output logic             parity,
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q
);

    logic [FLAG_W-1:0] flags;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        nand_bit u_bit (
            .a (A[i]),
            .b (B[i]),
            .y (result[i])
        );
    end

    assign flags[FLAG_ZERO]   = ~|result;
    assign flags[FLAG_ONES]   = &result;
    assign flags[FLAG_PARITY] = ^result;

    assign zero   = flags[FLAG_ZERO];
    assign ones   = flags[FLAG_ONES];
    assign parity = flags[FLAG_PARITY];

    // Reset value keeps zero_q consistent with the cleared result_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result;
            zero_q   <= flags[FLAG_ZERO];
        end
    end

endmodule

// File: tb/tb_nand_gate.sv
// tb/tb_nand_gate.sv - self-checking bench for nand_gate against a behavioural model
module tb_nand_gate;

    localparam int W = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] result;
    logic         zero;
    logic         ones;
    logic         parity;
    logic [W-1:0] result_q;
    logic         zero_q;

    int n_cmp  = 0;
    int n_fail = 0;

    nand_gate #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .result   (result),
        .zero     (zero),
        .ones     (ones),
        .parity   (parity),
        .result_q (result_q),
        .zero_q   (zero_q)
    );

    always #5 clk = ~clk;

    function automatic int model_result(int a, int b);
        return MAXV - (a & b);
    endfunction

    function automatic int model_parity(int v);
        int cnt = 0;
        for (int k = 0; k < W; k++) cnt += (v >> k) & 1;
        return cnt % 2;
    endfunction

    task automatic check_comb(string name, int a, int b);
        int e;
        e = model_result(a, b);
        n_cmp++;
        if (result !== W'(e)) begin
            n_fail++;
            $display("FAIL %s result A=%0h B=%0h got %b want %b", name, a, b, result, W'(e));
        end
        n_cmp++;
        if (zero !== (e == 0)) begin
            n_fail++;
            $display("FAIL %s zero A=%0h B=%0h got %b want %b", name, a, b, zero, (e == 0));
        end
        n_cmp++;
        if (ones !== (e == MAXV)) begin
            n_fail++;
            $display("FAIL %s ones A=%0h B=%0h got %b want %b", name, a, b, ones, (e == MAXV));
        end
        n_cmp++;
        if (parity !== 1'(model_parity(e))) begin
            n_fail++;
            $display("FAIL %s parity A=%0h B=%0h got %b want %0d", name, a, b, parity, model_parity(e));
        end
    endtask

    task automatic check_reg(string name, int e);
        n_cmp++;
        if (result_q !== W'(e)) begin
            n_fail++;
            $display("FAIL %s result_q got %b want %b", name, result_q, W'(e));
        end
        n_cmp++;
        if (zero_q !== (e == 0)) begin
            n_fail++;
            $display("FAIL %s zero_q got %b want %b", name, zero_q, (e == 0));
        end
    endtask

    task automatic test_reset();
        A = 4'b0011; B = 4'b0101;
        repeat (3) @(posedge clk);
        #1 check_reg("reset_hold", 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 check_reg("reset_release", model_result(3, 5));
    endtask

    task automatic test_basic();
        @(negedge clk);
        A = 4'b1010; B = 4'b1011;
        #1 check_comb("case1", 'b1010, 'b1011);
        A = 4'b1111; B = 4'b1111;
        #1 check_comb("case3", 'hf, 'hf);
        @(posedge clk);
        #1 check_reg("case3_reg", 0);
    endtask

    task automatic test_hold();
        @(negedge clk);
        A = 4'b0000; B = 4'b1111;
        #1 check_comb("case2", 0, 'hf);
        for (int t = 0; t < 11; t++) begin
            #10;
            n_cmp++;
            if (result !== W'(model_result(0, 'hf))) begin
                n_fail++;
                $display("FAIL hold step %0d got %b want %b", t, result, W'(model_result(0, 'hf)));
            end
        end
    endtask

    task automatic test_sweep();
        for (int a = 0; a <= MAXV; a++) begin
            for (int b = 0; b <= MAXV; b++) begin
                @(negedge clk);
                A = W'(a); B = W'(b);
                #1 check_comb("sweep", a, b);
                @(posedge clk);
                #1 check_reg("sweep_reg", model_result(a, b));
            end
        end
    endtask

    task automatic test_back_to_back();
        int pa, pb;
        @(negedge clk);
        pa = int'($urandom_range(MAXV)); pb = int'($urandom_range(MAXV));
        A = W'(pa); B = W'(pb);
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1 check_reg("b2b_reg", model_result(pa, pb));
            @(negedge clk);
            pa = int'($urandom_range(MAXV)); pb = int'($urandom_range(MAXV));
            A = W'(pa); B = W'(pb);
            #1 check_comb("b2b", pa, pb);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        A = 4'b1010; B = 4'b1111;
        @(posedge clk);
        #1 check_reg("load_0101", 'b0101);
        #2 rst = 1'b1;
        #1 check_reg("async_clear", 0);
        check_comb("comb_in_reset", 'b1010, 'hf);
        A = 4'b0001; B = 4'b0001;
        @(posedge clk);
        #1 check_reg("reset_ignores_edge", 0);
        @(negedge clk) rst = 1'b0;
        #1 check_reg("released_no_edge", 0);
        @(posedge clk);
        #1 check_reg("reload_after_release", model_result(1, 1));
    endtask

    task automatic test_x_confine();
        logic [W-1:0] ax;
        ax = 4'b1x10;
        @(negedge clk);
        A = ax; B = 4'b1111;
        #1;
        n_cmp++;
        if (result[3] !== 1'b0 || result[1] !== 1'b0 || result[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL x_confine got %b want 0?01", result);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_sweep();
        test_back_to_back();
        test_async_reset();
        test_x_confine();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
